// File: rtl/knn_scheduler.sv
// Sequences a distance calculator over chunked training samples and keeps the K nearest (distance, type).
// Define KNN_VOTE_EN to add the majority-vote stage and the class_out port.
module knn_scheduler #(
  parameter int M            = 4,
  parameter int N            = 4,
  parameter int W            = 16,
  parameter int MAX_ELEMENTS = 8,
  parameter int TYPE_W       = 2,
  parameter int K            = 3,
  parameter int NUM_SAMPLES  = 16,
  parameter int ADDR_W       = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           mem_rd_en,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic [MAX_ELEMENTS*W+TYPE_W-1:0] mem_rd_data,
  output logic                           dc_ready,
  output logic [W*M*N-1:0]               dc_training_data,
  output logic [TYPE_W-1:0]              dc_training_type,
  input  logic [W-1:0]                   dc_distance,
  input  logic [TYPE_W-1:0]              dc_data_type,
  input  logic                           dc_done,
  input  logic                           dc_data_request,
  output logic [K*W-1:0]                 knn_dist,
  output logic [K*TYPE_W-1:0]            knn_type
`ifdef KNN_VOTE_EN
  ,
  output logic [TYPE_W-1:0]              class_out
`endif
);

  localparam int CHUNKS    = (M*N + MAX_ELEMENTS - 1) / MAX_ELEMENTS;
  localparam int SAMPLE_W  = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam int CHUNK_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int LANE_BITS = (MAX_ELEMENTS*W < W*M*N) ? MAX_ELEMENTS*W : W*M*N;
  localparam int CNT_W     = $clog2(K + 1);
  localparam logic [W-1:0]        DIST_INIT   = {1'b0, {(W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] LAST_SAMPLE = SAMPLE_W'(NUM_SAMPLES - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, KICK, WAIT_DC, INSERT,
`ifdef KNN_VOTE_EN
    VOTE,
`endif
    FINISH
  } state_t;

  state_t              state;
  logic [SAMPLE_W-1:0] sample;
  logic [CHUNK_W-1:0]  chunk;
  logic [W-1:0]        new_dist;
  logic [TYPE_W-1:0]   new_type;
  logic [W-1:0]        dist_q   [K];
  logic [TYPE_W-1:0]   type_q   [K];
  logic [W-1:0]        dist_ins [K];
  logic [TYPE_W-1:0]   type_ins [K];
  logic [K-1:0]        lt;
  logic [W*M*N-1:0]    chunk_ext;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [SAMPLE_W-1:0] s,
                                                input logic [CHUNK_W-1:0] c);
    return ADDR_W'(s) * ADDR_W'(CHUNKS) + ADDR_W'(c);
  endfunction

  always_comb begin
    chunk_ext = '0;
    chunk_ext[LANE_BITS-1:0] = mem_rd_data[TYPE_W +: LANE_BITS];
  end

  // lt is monotone over a sorted list, so lt[j-1] set means the new entry landed below j.
  always_comb begin
    for (int unsigned j = 0; j < K; j++) lt[j] = new_dist < dist_q[j];
    dist_ins[0] = lt[0] ? new_dist : dist_q[0];
    type_ins[0] = lt[0] ? new_type : type_q[0];
    for (int unsigned j = 1; j < K; j++) begin
      dist_ins[j] = lt[j-1] ? dist_q[j-1] : (lt[j] ? new_dist : dist_q[j]);
      type_ins[j] = lt[j-1] ? type_q[j-1] : (lt[j] ? new_type : type_q[j]);
    end
  end

  always_comb begin
    knn_dist = '0;
    knn_type = '0;
    for (int unsigned j = 0; j < K; j++) begin
      knn_dist[j*W +: W]           = dist_q[j];
      knn_type[j*TYPE_W +: TYPE_W] = type_q[j];
    end
  end

`ifdef KNN_VOTE_EN
  logic [TYPE_W-1:0] cand;
  logic [TYPE_W-1:0] best_class;
  logic [CNT_W-1:0]  best_cnt;
  logic [CNT_W-1:0]  cnt;

  always_comb begin
    cnt = '0;
    for (int unsigned j = 0; j < K; j++)
      if (type_q[j] == cand) cnt = cnt + CNT_W'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      mem_rd_en        <= 1'b0;
      mem_addr         <= '0;
      dc_ready         <= 1'b0;
      dc_training_data <= '0;
      dc_training_type <= '0;
      sample           <= '0;
      chunk            <= '0;
      new_dist         <= '0;
      new_type         <= '0;
      for (int unsigned j = 0; j < K; j++) begin
        dist_q[j] <= DIST_INIT;
        type_q[j] <= '0;
      end
`ifdef KNN_VOTE_EN
      cand       <= '0;
      best_class <= '0;
      best_cnt   <= '0;
      class_out  <= '0;
`endif
    end else begin
      mem_rd_en <= 1'b0;
      dc_ready  <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy      <= 1'b1;
          sample    <= '0;
          chunk     <= '0;
          mem_addr  <= '0;
          mem_rd_en <= 1'b1;
          for (int unsigned j = 0; j < K; j++) begin
            dist_q[j] <= DIST_INIT;
            type_q[j] <= '0;
          end
`ifdef KNN_VOTE_EN
          class_out <= '0;
`endif
          state <= FETCH;
        end
        FETCH: state <= LOAD;
        LOAD: begin
          dc_training_data <= chunk_ext;
          if (chunk == '0) dc_training_type <= mem_rd_data[TYPE_W-1:0];
          dc_ready <= 1'b1;
          state    <= KICK;
        end
        KICK: state <= WAIT_DC;
        WAIT_DC: begin
          if (dc_done) begin
            new_dist <= dc_distance;
            new_type <= dc_data_type;
            state    <= INSERT;
          end else if (dc_data_request) begin
            chunk     <= chunk + CHUNK_W'(1);
            mem_addr  <= addr_of(sample, chunk + CHUNK_W'(1));
            mem_rd_en <= 1'b1;
            state     <= FETCH;
          end
        end
        INSERT: begin
          for (int unsigned j = 0; j < K; j++) begin
            dist_q[j] <= dist_ins[j];
            type_q[j] <= type_ins[j];
          end
          if (sample < LAST_SAMPLE) begin
            sample    <= sample + SAMPLE_W'(1);
            chunk     <= '0;
            mem_addr  <= addr_of(sample + SAMPLE_W'(1), '0);
            mem_rd_en <= 1'b1;
            state     <= FETCH;
          end else begin
`ifdef KNN_VOTE_EN
            cand       <= '0;
            best_class <= '0;
            best_cnt   <= '0;
            state      <= VOTE;
`else
            done  <= 1'b1;
            state <= FINISH;
`endif
          end
        end
`ifdef KNN_VOTE_EN
        // Strict > while scanning upward keeps the smaller class on equal counts.
        VOTE: begin
          if (cnt > best_cnt) begin
            best_cnt   <= cnt;
            best_class <= cand;
          end
          if (cand == '1) begin
            class_out <= (cnt > best_cnt) ? cand : best_class;
            done      <= 1'b1;
            state     <= FINISH;
          end else begin
            cand <= cand + TYPE_W'(1);
          end
        end
`endif
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_scheduler.sv
// Scoreboard bench for knn_scheduler: memory and distance-calculator models, reference K-nearest model.
module tb_knn_scheduler;
  localparam int M = 2, N = 2, W = 16, MAXE = 2, TW = 2, K = 3, NS = 4, AW = 8;
  localparam int CHUNKS = 2;
  localparam int WORD_W = MAXE*W + TW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, busy, done, mem_rd_en, dc_ready;
  logic [AW-1:0]     mem_addr;
  logic [WORD_W-1:0] mem_rd_data;
  logic [W*M*N-1:0]  dc_training_data;
  logic [TW-1:0]     dc_training_type, dc_data_type;
  logic [W-1:0]      dc_distance;
  logic              dc_done, dc_data_request;
  logic [K*W-1:0]    knn_dist;
  logic [K*TW-1:0]   knn_type;
`ifdef KNN_VOTE_EN
  logic [TW-1:0]     class_out;
`endif

  knn_scheduler #(.M(M), .N(N), .W(W), .MAX_ELEMENTS(MAXE), .TYPE_W(TW), .K(K),
                  .NUM_SAMPLES(NS), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .dc_ready(dc_ready), .dc_training_data(dc_training_data),
    .dc_training_type(dc_training_type), .dc_distance(dc_distance),
    .dc_data_type(dc_data_type), .dc_done(dc_done), .dc_data_request(dc_data_request),
    .knn_dist(knn_dist), .knn_type(knn_type)
`ifdef KNN_VOTE_EN
    , .class_out(class_out)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Sample memory with one-cycle read latency.
  logic [WORD_W-1:0] mem [NS*CHUNKS];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr[2:0]];

  // Distance calculator: sum of squares against an all-zero input, one request per chunk.
  function automatic logic [W-1:0] chunk_sq(input logic [W*M*N-1:0] d);
    logic [W-1:0] s = '0;
    logic [W-1:0] e;
    for (int i = 0; i < MAXE; i++) begin
      e = d[i*W +: W];
      s = s + W'(e * e);
    end
    return s;
  endfunction

  logic [W-1:0] acc;
  int           calc_chunk;
  always @(posedge clk) begin
    dc_done         <= 1'b0;
    dc_data_request <= 1'b0;
    if (rst) begin
      acc          <= '0;
      calc_chunk   <= 0;
      dc_distance  <= '0;
      dc_data_type <= '0;
    end else if (dc_ready) begin
      if (calc_chunk == CHUNKS-1) begin
        dc_distance  <= acc + chunk_sq(dc_training_data);
        dc_data_type <= dc_training_type;
        dc_done      <= 1'b1;
        acc          <= '0;
        calc_chunk   <= 0;
      end else begin
        acc             <= acc + chunk_sq(dc_training_data);
        calc_chunk      <= calc_chunk + 1;
        dc_data_request <= 1'b1;
      end
    end
  end

  typedef struct packed {
    logic [K*W-1:0]  d;
    logic [K*TW-1:0] t;
    logic [TW-1:0]   cls;
  } exp_t;

  exp_t sb [$];
  int   elem [NS][M*N];
  int   typ  [NS];

  task automatic load_mem();
    logic [WORD_W-1:0] w;
    for (int s = 0; s < NS; s++)
      for (int c = 0; c < CHUNKS; c++) begin
        w = '0;
        w[TW-1:0] = TW'(typ[s]);
        for (int i = 0; i < MAXE; i++) w[TW + i*W +: W] = W'(elem[s][c*MAXE + i]);
        mem[s*CHUNKS + c] = w;
      end
  endtask

  task automatic set_uniform(input int v0, v1, v2, v3, input int t0, t1, t2, t3);
    int v [NS];
    v = '{v0, v1, v2, v3};
    typ = '{t0, t1, t2, t3};
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < M*N; i++) elem[s][i] = v[s];
    load_mem();
  endtask

  // Selection of the K smallest distances, lowest sample index first on ties.
  function automatic exp_t ref_model();
    exp_t e;
    int   dd [NS];
    bit   used [NS];
    int   best;
    int   cnt [4];
    e = '0;
    for (int s = 0; s < NS; s++) begin
      dd[s] = 0;
      used[s] = 1'b0;
      for (int i = 0; i < M*N; i++) dd[s] += elem[s][i] * elem[s][i];
    end
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int j = 0; j < K; j++) begin
      best = -1;
      for (int s = 0; s < NS; s++)
        if (!used[s] && (best < 0 || dd[s] < dd[best])) best = s;
      used[best] = 1'b1;
      e.d[j*W +: W]  = W'(dd[best]);
      e.t[j*TW +: TW] = TW'(typ[best]);
      cnt[typ[best]]++;
    end
    for (int c = 1; c < 4; c++) if (cnt[c] > cnt[e.cls]) e.cls = TW'(c);
    return e;
  endfunction

  int   exp_addr = 0;
  int   ready_cnt = 0;
  int   done_cnt = 0;
  logic rd_d1 = 1'b0, rd_d2 = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_d1 = 1'b0;
        rd_d2 = 1'b0;
      end else begin
        if (mem_rd_en) begin
          check_eq("mem_addr", 64'(mem_addr), 64'(exp_addr));
          exp_addr++;
        end
        if (dc_ready || rd_d2) check_eq("ready_latency", 64'(dc_ready), 64'(rd_d2));
        if (dc_ready) ready_cnt++;
        if (done) begin
          done_cnt++;
          check_eq("busy_at_done", 64'(busy), 64'd1);
          if (sb.size() == 0) begin
            check_eq("sb_nonempty", 64'd0, 64'd1);
          end else begin
            e = sb.pop_front();
            for (int j = 0; j < K; j++) begin
              check_eq($sformatf("knn_dist[%0d]", j), 64'(knn_dist[j*W +: W]), 64'(e.d[j*W +: W]));
              check_eq($sformatf("knn_type[%0d]", j), 64'(knn_type[j*TW +: TW]), 64'(e.t[j*TW +: TW]));
            end
`ifdef KNN_VOTE_EN
            check_eq("class_out", 64'(class_out), 64'(e.cls));
`endif
          end
        end
        rd_d2 = rd_d1;
        rd_d1 = mem_rd_en;
      end
    end
  end

  task automatic run(input bit busy_start);
    int cyc = 0;
    sb.push_back(ref_model());
    exp_addr  = 0;
    ready_cnt = 0;
    done_cnt  = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    if (busy_start) begin
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("done_seen", 64'(done), 64'd1);
    @(negedge clk);
    check_eq("busy_after_done", 64'(busy), 64'd0);
    check_eq("done_one_cycle", 64'(done), 64'd0);
    check_eq("done_count", 64'(done_cnt), 64'd1);
    check_eq("ready_count", 64'(ready_cnt), 64'(NS*CHUNKS));
    check_eq("fetch_count", 64'(exp_addr), 64'(NS*CHUNKS));
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    check_eq({tag, "_dist"}, 64'(knn_dist), 64'({K{16'h7FFF}}));
    check_eq({tag, "_type"}, 64'(knn_type), 64'd0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_cleared("reset");
    check_eq("reset_done", 64'(done), 64'd0);
    check_eq("reset_ready", 64'(dc_ready), 64'd0);
`ifdef KNN_VOTE_EN
    check_eq("reset_class", 64'(class_out), 64'd0);
`endif

    // Basic run with a start pulse while busy, then a clean rerun.
    set_uniform(3, 1, 2, 5, 1, 2, 1, 0);
    run(1'b1);
    run(1'b0);

    // Ties: equal distances keep sample order.
    set_uniform(2, 2, 1, 2, 3, 0, 1, 2);
    run(1'b0);

    // Vote with counts 1/1/1 over classes 3, 2, 1.
    set_uniform(3, 1, 2, 5, 1, 3, 2, 0);
    run(1'b0);

    // Reset during sample 2.
    set_uniform(3, 1, 2, 5, 1, 2, 1, 0);
    exp_addr = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!(mem_rd_en && mem_addr == AW'(4)) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("reach_sample2", 64'(mem_addr), 64'd4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("midrun_reset");
    run(1'b0);

    // Random element values per lane.
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < NS; s++) begin
        typ[s] = int'($urandom_range(0, 3));
        for (int i = 0; i < M*N; i++) elem[s][i] = int'($urandom_range(0, 20));
      end
      load_mem();
      run(1'b0);
    end

    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
